// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch constants, the {pc, instr} fetch entry type and a PC alignment helper
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry {pc, instr} FIFO; ports: clk, rst, flush (beats push/pop), push + push_pc/push_instr, pop, head_pc/head_instr, count
module fetch_buf
  import riscv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [XLEN-1:0]  push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  output logic [XLEN-1:0]  head_pc,
  output logic [INSTR_W-1:0] head_instr,
  output logic [1:0]       count
);
  fetch_entry_t e0_q, e0_d, e1_q, e1_d, din;
  logic [1:0] count_q, count_d, kept;
  always_comb begin
    din = '{pc: push_pc, instr: push_instr};
    // entries surviving the pop; the push lands right behind them
    kept = count_q - {1'b0, pop};
    e0_d = flush ? e0_q : (push && kept == 2'd0) ? din : pop ? e1_q : e0_q;
    e1_d = flush ? e1_q : (push && kept == 2'd1) ? din : e1_q;
    count_d = flush ? 2'd0 : kept + {1'b0, push};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q <= '0;
      e1_q <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      count_q <= count_d;
    end
  end
  assign head_pc = e0_q.pc;
  assign head_instr = e0_q.instr;
  assign count = count_q;
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !pop && !flush && count_q == 2'd2));
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, ROM read issue and redirect squash; ports: clk, rst, imem_re/imem_a/imem_rd (ROM), redirect/redirect_pc, out_valid/out_ready/out_instr/out_pc (decode)
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int N = 1024,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_re,
  output logic [AW-1:0] imem_a,
  input  logic [31:0]   imem_rd,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc
);
  logic [31:0] fetch_pc_q, fetch_pc_d, inflight_pc_q, inflight_pc_d;
  logic inflight_q, inflight_d, pop, push;
  logic [1:0] count;
  logic [2:0] occ;
  assign out_valid = count != 2'd0;
  assign imem_a = fetch_pc_q[AW+1:2];
  always_comb begin
    pop = out_valid && out_ready && !redirect;
    push = inflight_q && !redirect;
    // an issue needs a queue slot that is still free once the in-flight word lands
    occ = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    imem_re = !rst && !redirect && occ < 3'd2;
    fetch_pc_d = redirect ? align_pc(redirect_pc) : imem_re ? fetch_pc_q + PC_STEP : fetch_pc_q;
    inflight_d = imem_re;
    inflight_pc_d = imem_re ? fetch_pc_q : inflight_pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end
  fetch_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (push),
    .pop        (pop),
    .push_pc    (inflight_pc_q),
    .push_instr (imem_rd),
    .head_pc    (out_pc),
    .head_instr (out_instr),
    .count      (count)
  );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboarded fetch bench with a ROM model, directed timing checks and random back-pressure/redirects
module tb_instr_fetch;
  localparam int N = 16;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic redirect = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_rd = 32'h0;
  logic imem_re, out_valid;
  logic [3:0] imem_a;
  logic [31:0] out_instr, out_pc;
  logic [31:0] rom [N];
  int n_chk = 0;
  int n_fail = 0;
  int n_pop = 0;
  exp_t exp_q[$];
  exp_t e_mon;
  logic [31:0] nxt_pc = RST_PC;

  always #5 clk = ~clk;

  instr_fetch #(.N(N), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_re     (imem_re),
    .imem_a      (imem_a),
    .imem_rd     (imem_rd),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
  );

  initial for (int i = 0; i < N; i++) rom[i] = 32'hA000_0000 + 32'(i);
  always @(posedge clk) if (imem_re) imem_rd <= rom[imem_a];

  function automatic logic [31:0] ref_instr(input logic [31:0] pc);
    return 32'hA000_0000 + ((pc >> 2) % N);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // reference: the accepted stream is consecutive PCs from the last reset/redirect target
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      nxt_pc = RST_PC;
    end else begin
      if (out_valid === 1'b1 && out_ready && !redirect) begin
        e_mon = exp_q.pop_front();
        chk("sb_pc", out_pc, e_mon.pc);
        chk("sb_instr", out_instr, e_mon.instr);
        n_pop++;
      end
      if (redirect) begin
        exp_q.delete();
        nxt_pc = {redirect_pc[31:2], 2'b00};
      end
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back('{nxt_pc, ref_instr(nxt_pc)});
      nxt_pc += 32'd4;
    end
  end

  initial begin
    repeat (3) tick;
    chk("rst_re", imem_re, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_addr", imem_a, RST_PC[5:2]);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("c0_re", imem_re, 1);
    tick;
    chk("c1_valid", out_valid, 0);
    tick;
    chk("c2_valid", out_valid, 1);
    chk("c2_pc", out_pc, RST_PC);
    repeat (6) tick;
    out_ready = 1'b0;
    repeat (5) tick;
    chk("stall_valid", out_valid, 1);
    chk("stall_re", imem_re, 0);
    out_ready = 1'b1;
    #1;
    chk("release_re", imem_re, 1);
    repeat (6) tick;
    out_ready = 1'b0;
    repeat (4) tick;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    chk("redir_full_re", imem_re, 0);
    tick;
    redirect = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("redir_t1_valid", out_valid, 0);
    chk("redir_t1_re", imem_re, 1);
    chk("redir_t1_addr", imem_a, 0);
    tick;
    chk("redir_t2_valid", out_valid, 0);
    tick;
    chk("redir_t3_valid", out_valid, 1);
    chk("redir_t3_pc", out_pc, 32'h100);
    repeat (4) tick;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0038;
    #1;
    chk("redir_pop_re", imem_re, 0);
    tick;
    redirect = 1'b0;
    chk("wrap_a14", imem_a, 14);
    chk("wrap_t1_valid", out_valid, 0);
    tick;
    chk("wrap_a15", imem_a, 15);
    chk("wrap_t2_valid", out_valid, 0);
    tick;
    chk("wrap_a0", imem_a, 0);
    chk("wrap_t3_valid", out_valid, 1);
    chk("wrap_t3_pc", out_pc, 32'h38);
    tick;
    chk("wrap_a1", imem_a, 1);
    chk("wrap_pc3c", out_pc, 32'h3C);
    tick;
    chk("wrap_pc40", out_pc, 32'h40);
    chk("wrap_instr40", out_instr, 32'hA000_0000);
    tick;
    chk("wrap_pc44", out_pc, 32'h44);
    repeat (2) tick;
    out_ready = 1'b0;
    repeat (2) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_pc", out_pc, 0);
    chk("mrst_addr", imem_a, RST_PC[5:2]);
    chk("mrst_re", imem_re, 1);
    out_ready = 1'b1;
    tick;
    chk("mrst_c1_valid", out_valid, 0);
    tick;
    chk("mrst_c2_valid", out_valid, 1);
    chk("mrst_c2_pc", out_pc, RST_PC);
    repeat (300) begin
      tick;
      out_ready = $urandom_range(0, 3) != 0;
      redirect = $urandom_range(0, 24) == 0;
      redirect_pc = $urandom;
    end
    redirect = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick;
    chk("min_pops", 32'(n_pop >= 150), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
